cam_tag_reducer: RTL and testbench

//  Downstream of the CAM subarray. Consumes the 32-bit tag_out vector beat by beat over a multi-step search sequence.

---
 rtl/cam_tag_reducer.sv | 236 +++++++++++++++++++++++
 tb/tb_cam_tag_reducer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_tag_reducer.sv
// -----------------------------------------------------------------------------
// cam_tag_reducer
//
// Sits downstream of a CAM subarray. Folds a multi-beat sequence of tag_out
// vectors into one accumulated match vector, then reduces that vector to
// hit / lowest-match index / match count and offers the result on a
// valid/ready handshake. The running vector is exported on acc_tag so the
// subarray can use it as tag_in for chained searches.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   tag_valid  in   1      beat present on tag_in
//   tag_ready  out  1      block can accept a beat (IDLE / ACCUM)
//   tag_in     in   TAG_W  tag_out of CAM subarray
//   tag_first  in   1      beat opens a new group
//   tag_last   in   1      beat closes the group
//   acc_mode   in   2      fold op: 00 LOAD, 01 AND, 10 OR, 11 XOR
//   acc_tag    out  TAG_W  running accumulated vector (0 in IDLE)
//   res_valid  out  1      result available
//   res_ready  in   1      consumer takes result
//   res_tag    out  TAG_W  final accumulated vector
//   res_hit    out  1      OR-reduction of res_tag
//   res_index  out  IDX_W  lowest set bit of res_tag (0 if none)
//   res_count  out  CNT_W  popcount of res_tag
//   res_beats  out  4      beats folded into this result
//   seq_err    out  1      one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module cam_tag_reducer #(
    parameter int TAG_W    = 32,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 6,
    parameter int MAX_BEAT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tag_valid,
    output logic             tag_ready,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             tag_first,
    input  logic             tag_last,
    input  logic [1:0]       acc_mode,
    output logic [TAG_W-1:0] acc_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_index,
    output logic [CNT_W-1:0] res_count,
    output logic [3:0]       res_beats,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REDUCE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_BEAT_C = 4'(MAX_BEAT);

    // Number of set bits in the vector.
    function automatic logic [CNT_W-1:0] pop_count(input logic [TAG_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < TAG_W; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Index of the lowest set bit; scanning downward lets the lowest hit win.
    function automatic logic [IDX_W-1:0] low_index(input logic [TAG_W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = TAG_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One fold step of the accumulator.
    function automatic logic [TAG_W-1:0] fold(input logic [TAG_W-1:0] a,
                                              input logic [TAG_W-1:0] b,
                                              input logic [1:0]       mode);
        logic [TAG_W-1:0] r;
        case (mode)
            2'b00:   r = b;
            2'b01:   r = a & b;
            2'b10:   r = a | b;
            2'b11:   r = a ^ b;
            default: r = b;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [TAG_W-1:0] acc_q, acc_d;
    logic [3:0]       beats_q, beats_d;
    logic             tag_ready_q, tag_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_hit_q, res_hit_d;
    logic [IDX_W-1:0] res_index_q, res_index_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic [3:0]       res_beats_q, res_beats_d;
    logic             seq_err_q, seq_err_d;

    logic             beat_s;
    logic [3:0]       beats_inc_s;

    assign beat_s      = tag_valid & tag_ready_q;
    assign beats_inc_s = beats_q + 4'd1;

    // Next-state, accumulator and result computation.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_hit_d   = res_hit_q;
        res_index_d = res_index_q;
        res_count_d = res_count_q;
        res_beats_d = res_beats_q;
        seq_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (beat_s) begin
                    // First beat always loads, whatever acc_mode says.
                    acc_d     = tag_in;
                    beats_d   = 4'd1;
                    seq_err_d = ~tag_first;
                    state_d   = tag_last ? ST_REDUCE : ST_ACCUM;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (beat_s) begin
                    if (tag_first) begin
                        // Unexpected group start: drop the partial group.
                        acc_d     = tag_in;
                        beats_d   = 4'd1;
                        seq_err_d = 1'b1;
                        state_d   = tag_last ? ST_REDUCE : ST_ACCUM;
                    end else begin
                        acc_d   = fold(acc_q, tag_in, acc_mode);
                        beats_d = beats_inc_s;
                        if (tag_last) begin
                            state_d = ST_REDUCE;
                        end else if (beats_inc_s == MAX_BEAT_C) begin
                            // Forced close of a group that never saw tag_last.
                            state_d   = ST_REDUCE;
                            seq_err_d = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_REDUCE: begin
                res_tag_d   = acc_q;
                res_hit_d   = |acc_q;
                res_index_d = low_index(acc_q);
                res_count_d = pop_count(acc_q);
                res_beats_d = beats_q;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                // First HOLD cycle raises res_valid; afterwards wait for the consumer.
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    acc_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tag_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            beats_q     <= 4'd0;
            tag_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_hit_q   <= 1'b0;
            res_index_q <= '0;
            res_count_q <= '0;
            res_beats_q <= 4'd0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            tag_ready_q <= tag_ready_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_hit_q   <= res_hit_d;
            res_index_q <= res_index_d;
            res_count_q <= res_count_d;
            res_beats_q <= res_beats_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign tag_ready = tag_ready_q;
    assign acc_tag   = acc_q;
    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_hit   = res_hit_q;
    assign res_index = res_index_q;
    assign res_count = res_count_q;
    assign res_beats = res_beats_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_cam_tag_reducer.sv
// -----------------------------------------------------------------------------
// tb_cam_tag_reducer
//
// Directed bench for cam_tag_reducer. A behavioural model (group open flag,
// accumulated word, pending-result age) predicts every output each cycle and a
// compare process checks the DUT on the falling edge; directed tasks add
// hand-computed literal checks for the main scenarios.
// -----------------------------------------------------------------------------
module tb_cam_tag_reducer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tag_valid;
    logic        tag_ready;
    logic [31:0] tag_in;
    logic        tag_first;
    logic        tag_last;
    logic [1:0]  acc_mode;
    logic [31:0] acc_tag;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_tag;
    logic        res_hit;
    logic [4:0]  res_index;
    logic [5:0]  res_count;
    logic [3:0]  res_beats;
    logic        seq_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    cam_tag_reducer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_valid (tag_valid),
        .tag_ready (tag_ready),
        .tag_in    (tag_in),
        .tag_first (tag_first),
        .tag_last  (tag_last),
        .acc_mode  (acc_mode),
        .acc_tag   (acc_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_tag   (res_tag),
        .res_hit   (res_hit),
        .res_index (res_index),
        .res_count (res_count),
        .res_beats (res_beats),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_acc, m_res;
    logic        m_open, m_busy, m_seq;
    int          m_age, m_beats, m_res_beats;

    function automatic logic [4:0] ref_index(input logic [31:0] v);
        int k;
        k = 0;
        while (k < 32 && !v[k]) k++;
        return (k == 32) ? 5'd0 : 5'(k);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 32'd0; m_res = 32'd0; m_open = 1'b0; m_busy = 1'b0;
            m_seq = 1'b0; m_age = 0; m_beats = 0; m_res_beats = 0;
        end else begin
            m_seq = 1'b0;
            if (m_busy) begin
                if (m_age >= 2 && res_ready) begin
                    m_busy = 1'b0;
                    m_acc  = 32'd0;
                end else if (m_age < 2) begin
                    m_age++;
                end
            end else if (tag_valid) begin
                if (!m_open || tag_first) begin
                    m_seq   = m_open ? 1'b1 : !tag_first;
                    m_acc   = tag_in;
                    m_beats = 1;
                    m_open  = 1'b1;
                end else begin
                    case (acc_mode)
                        2'd0:    m_acc = tag_in;
                        2'd1:    m_acc = m_acc & tag_in;
                        2'd2:    m_acc = m_acc | tag_in;
                        default: m_acc = m_acc ^ tag_in;
                    endcase
                    m_beats++;
                end
                if (tag_last || m_beats == 8) begin
                    if (!tag_last) m_seq = 1'b1;
                    m_open      = 1'b0;
                    m_busy      = 1'b1;
                    m_age       = 0;
                    m_res       = m_acc;
                    m_res_beats = m_beats;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1 ("m_tag_ready", tag_ready, !m_busy);
            chk32("m_acc_tag",   acc_tag,   m_acc);
            chk1 ("m_res_valid", res_valid, m_busy && m_age >= 2);
            chk1 ("m_seq_err",   seq_err,   m_seq);
            if (m_busy && m_age >= 2) begin
                chk32("m_res_tag",   res_tag, m_res);
                chk1 ("m_res_hit",   res_hit, |m_res);
                chk32("m_res_index", {27'd0, res_index}, {27'd0, ref_index(m_res)});
                chk32("m_res_count", {26'd0, res_count}, 32'($countones(m_res)));
                chk32("m_res_beats", {28'd0, res_beats}, 32'(m_res_beats));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic beat(input logic [31:0] d, input logic f, input logic l, input logic [1:0] m);
        tag_in = d; tag_first = f; tag_last = l; acc_mode = m; tag_valid = 1'b1;
        @(posedge clk); #2;
        tag_valid = 1'b0; tag_first = 1'b0; tag_last = 1'b0;
    endtask

    task automatic wait_res(input string name, input logic [31:0] t, input logic h,
                            input logic [4:0] i, input logic [5:0] c, input logic [3:0] b,
                            input int hold, output int lat);
        bit found;
        found = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            lat++;
            if (res_valid === 1'b1) found = 1'b1;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL %s_timeout: res_valid never rose within 20 cycles", name);
            @(posedge clk); #2;
        end else begin
            chk32({name, "_tag"}, res_tag, t);
            chk1 ({name, "_hit"}, res_hit, h);
            chk32({name, "_index"}, {27'd0, res_index}, {27'd0, i});
            chk32({name, "_count"}, {26'd0, res_count}, {26'd0, c});
            chk32({name, "_beats"}, {28'd0, res_beats}, {28'd0, b});
            if (hold > 0) begin
                // Offer a beat under backpressure; it must not be taken.
                tag_in = 32'hDEAD_BEEF; tag_first = 1'b1; tag_last = 1'b1; tag_valid = 1'b1;
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    chk32({name, "_bp_tag"}, res_tag, t);
                    chk1 ({name, "_bp_ready"}, tag_ready, 1'b0);
                    chk1 ({name, "_bp_valid"}, res_valid, 1'b1);
                end
                tag_valid = 1'b0; tag_first = 1'b0; tag_last = 1'b0;
            end
            res_ready = 1'b1;
            @(posedge clk); #2;
            res_ready = 1'b0;
            @(negedge clk);
            chk1 ({name, "_idle_ready"}, tag_ready, 1'b1);
            chk1 ({name, "_idle_valid"}, res_valid, 1'b0);
            chk32({name, "_idle_acc"}, acc_tag, 32'd0);
            @(posedge clk); #2;
        end
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; tag_valid = 1'b0; tag_in = 32'd0; tag_first = 1'b0;
        tag_last = 1'b0; acc_mode = 2'd0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk1 ("rst_tag_ready", tag_ready, 1'b1);
        chk32("rst_acc_tag",   acc_tag, 32'd0);
        chk1 ("rst_res_valid", res_valid, 1'b0);
        chk32("rst_res_tag",   res_tag, 32'd0);
        chk1 ("rst_res_hit",   res_hit, 1'b0);
        chk32("rst_res_cnt",   {21'd0, res_index, res_count}, 32'd0);
        chk32("rst_res_beats", {28'd0, res_beats}, 32'd0);
        chk1 ("rst_seq_err",   seq_err, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single beat, result two cycles after acceptance.
        beat(32'hAAAA_AAAA, 1'b1, 1'b1, 2'b00);
        wait_res("single", 32'hAAAA_AAAA, 1'b1, 5'd1, 6'd16, 4'd1, 0, lat);
        chk32("single_latency", 32'(lat), 32'd3);

        // AND chain.
        beat(32'hFFFF_0000, 1'b1, 1'b0, 2'b00);
        beat(32'h0F0F_0F0F, 1'b0, 1'b1, 2'b01);
        wait_res("and", 32'h0F0F_0000, 1'b1, 5'd16, 6'd8, 4'd2, 0, lat);

        // OR then XOR.
        beat(32'h0000_00F0, 1'b1, 1'b0, 2'b00);
        beat(32'h0000_0F00, 1'b0, 1'b0, 2'b10);
        beat(32'h0000_0330, 1'b0, 1'b1, 2'b11);
        wait_res("orxor", 32'h0000_0CC0, 1'b1, 5'd6, 6'd4, 4'd3, 0, lat);

        // Empty and full vectors.
        beat(32'h0000_0000, 1'b1, 1'b1, 2'b00);
        wait_res("empty", 32'h0000_0000, 1'b0, 5'd0, 6'd0, 4'd1, 0, lat);
        beat(32'hFFFF_FFFF, 1'b1, 1'b1, 2'b00);
        wait_res("full", 32'hFFFF_FFFF, 1'b1, 5'd0, 6'd32, 4'd1, 0, lat);

        // Backpressure for five cycles with a beat offered.
        beat(32'h1234_5678, 1'b1, 1'b1, 2'b00);
        wait_res("bp", 32'h1234_5678, 1'b1, 5'd3, 6'd13, 4'd1, 5, lat);

        // Beat without tag_first in IDLE.
        beat(32'h0000_0011, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        chk1("nofirst_seq_err", seq_err, 1'b1);
        @(posedge clk); #2;
        wait_res("nofirst", 32'h0000_0011, 1'b1, 5'd0, 6'd2, 4'd1, 0, lat);

        // Restart inside a group.
        beat(32'h0000_00F0, 1'b1, 1'b0, 2'b00);
        beat(32'h0000_000C, 1'b1, 1'b1, 2'b00);
        @(negedge clk);
        chk1("restart_seq_err", seq_err, 1'b1);
        @(posedge clk); #2;
        wait_res("restart", 32'h0000_000C, 1'b1, 5'd2, 6'd2, 4'd1, 0, lat);

        // Forced close after eight beats; ninth opens a new group.
        for (int k = 0; k < 8; k++) begin
            beat(32'd1 << k, (k == 0), 1'b0, 2'b10);
        end
        @(negedge clk);
        chk1("forced_seq_err", seq_err, 1'b1);
        chk1("forced_ready",   tag_ready, 1'b0);
        @(posedge clk); #2;
        wait_res("forced", 32'h0000_00FF, 1'b1, 5'd0, 6'd8, 4'd8, 0, lat);
        beat(32'h0000_0100, 1'b1, 1'b1, 2'b00);
        wait_res("ninth", 32'h0000_0100, 1'b1, 5'd8, 6'd1, 4'd1, 0, lat);

        // Reset in the middle of a group.
        beat(32'h0000_0001, 1'b1, 1'b0, 2'b00);
        beat(32'h0000_0002, 1'b0, 1'b0, 2'b10);
        beat(32'h0000_0004, 1'b0, 1'b0, 2'b10);
        chk32("pre_rst_acc", acc_tag, 32'h0000_0007);
        rst_n = 1'b0;
        #1;
        chk32("midrst_acc",   acc_tag, 32'd0);
        chk1 ("midrst_ready", tag_ready, 1'b1);
        chk1 ("midrst_valid", res_valid, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk1("postrst_valid", res_valid, 1'b0);
        end
        @(posedge clk); #2;

        // Group after reset still works.
        beat(32'h8000_0000, 1'b1, 1'b1, 2'b00);
        wait_res("after_rst", 32'h8000_0000, 1'b1, 5'd31, 6'd1, 4'd1, 0, lat);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
